// File: rtl/ariane_regfile_ff_bypass_if.sv
// rtl/ariane_regfile_ff_bypass_if.sv - read/write/clear bus of the bypassing flip-flop register file
interface ariane_regfile_ff_bypass_if #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned NUM_WORDS      = 32,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2
);
  localparam int unsigned ADDR_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic [NR_READ_PORTS-1:0][ADDR_W-1:0]      raddr_i;
  logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o;
  logic [NR_WRITE_PORTS-1:0][ADDR_W-1:0]     waddr_i;
  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NR_WRITE_PORTS-1:0]                 we_i;
  logic                                      clear_req_i;
  logic                                      clear_busy_o;
  logic                                      clear_done_o;
  logic                                      wr_conflict_o;

  modport master (
    output raddr_i, waddr_i, wdata_i, we_i, clear_req_i,
    input  rdata_o, clear_busy_o, clear_done_o, wr_conflict_o
  );

  modport slave (
    input  raddr_i, waddr_i, wdata_i, we_i, clear_req_i,
    output rdata_o, clear_busy_o, clear_done_o, wr_conflict_o
  );
endinterface

// File: rtl/ariane_regfile_ff_bypass.sv
// rtl/ariane_regfile_ff_bypass.sv - flip-flop register file with write bypass, conflict flag and bulk clear
module ariane_regfile_ff_bypass #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned NUM_WORDS      = 32,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter bit          ZERO_REG_ZERO  = 1'b1,
  parameter bit          BYPASS         = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  ariane_regfile_ff_bypass_if.slave   bus
);
  localparam int unsigned ADDR_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];
  logic [1:0]            r_state;
  logic [ADDR_W-1:0]     r_ptr;
  logic                  r_conflict;

  logic                  w_wen  [NUM_WORDS];
  logic [DATA_WIDTH-1:0] w_wdat [NUM_WORDS];
  logic                  w_conflict;
  logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] w_rdata;

  // Ports scanned in ascending order so the highest-index enabled port wins each word.
  always_comb begin
    for (int unsigned w = 0; w < NUM_WORDS; w++) begin
      w_wen[w]  = 1'b0;
      w_wdat[w] = '0;
      for (int unsigned j = 0; j < NR_WRITE_PORTS; j++) begin
        if (bus.we_i[j] && (bus.waddr_i[j] == ADDR_W'(w)) && !(ZERO_REG_ZERO && (w == 0))) begin
          w_wen[w]  = 1'b1;
          w_wdat[w] = bus.wdata_i[j];
        end
      end
    end
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int unsigned i = 0; i < NR_WRITE_PORTS; i++) begin
      for (int unsigned j = i + 1; j < NR_WRITE_PORTS; j++) begin
        if (bus.we_i[i] && bus.we_i[j] && (bus.waddr_i[i] == bus.waddr_i[j]) &&
            (32'(bus.waddr_i[i]) < NUM_WORDS) &&
            !(ZERO_REG_ZERO && (bus.waddr_i[i] == '0))) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NR_READ_PORTS; r++) begin
      w_rdata[r] = '0;
      if ((32'(bus.raddr_i[r]) < NUM_WORDS) && !(ZERO_REG_ZERO && (bus.raddr_i[r] == '0))) begin
        for (int unsigned w = 0; w < NUM_WORDS; w++) begin
          if (bus.raddr_i[r] == ADDR_W'(w)) begin
            w_rdata[r] = r_mem[w];
          end
        end
        if (BYPASS) begin
          for (int unsigned j = 0; j < NR_WRITE_PORTS; j++) begin
            if (bus.we_i[j] && (bus.waddr_i[j] == bus.raddr_i[r])) begin
              w_rdata[r] = bus.wdata_i[j];
            end
          end
        end
      end
    end
  end

  // A user write on the clear pointer's word takes precedence over the zeroing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned w = 0; w < NUM_WORDS; w++) begin
        r_mem[w] <= '0;
      end
    end else begin
      for (int unsigned w = 0; w < NUM_WORDS; w++) begin
        if (w_wen[w]) begin
          r_mem[w] <= w_wdat[w];
        end else if ((r_state == S_CLEAR) && (r_ptr == ADDR_W'(w))) begin
          r_mem[w] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_conflict;
      case (r_state)
        S_IDLE: begin
          if (bus.clear_req_i) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
          end
        end
        S_CLEAR: begin
          if (r_ptr == ADDR_W'(NUM_WORDS - 1)) begin
            r_state <= S_DONE;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rdata_o       = w_rdata;
  assign bus.clear_busy_o  = (r_state == S_CLEAR);
  assign bus.clear_done_o  = (r_state == S_DONE);
  assign bus.wr_conflict_o = r_conflict;
endmodule

// File: tb/tb_ariane_regfile_ff_bypass.sv
// tb/tb_ariane_regfile_ff_bypass.sv - scoreboard bench: 32-word bypassing file and 24-word non-bypassing file
module tb_ariane_regfile_ff_bypass;
  localparam int SEL_A_RD0 = 0, SEL_A_RD1 = 1, SEL_A_BUSY = 2, SEL_A_DONE = 3, SEL_A_CONF = 4;
  localparam int SEL_B_RD0 = 5, SEL_B_RD1 = 6, SEL_B_BUSY = 7, SEL_B_DONE = 8, SEL_B_CONF = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ariane_regfile_ff_bypass_if #(.DATA_WIDTH(64), .NUM_WORDS(32), .NR_READ_PORTS(2), .NR_WRITE_PORTS(2)) ifa ();
  ariane_regfile_ff_bypass_if #(.DATA_WIDTH(64), .NUM_WORDS(24), .NR_READ_PORTS(2), .NR_WRITE_PORTS(2)) ifb ();

  ariane_regfile_ff_bypass #(.DATA_WIDTH(64), .NUM_WORDS(32), .NR_READ_PORTS(2), .NR_WRITE_PORTS(2),
                             .ZERO_REG_ZERO(1'b1), .BYPASS(1'b1))
    u_dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));

  ariane_regfile_ff_bypass #(.DATA_WIDTH(64), .NUM_WORDS(24), .NR_READ_PORTS(2), .NR_WRITE_PORTS(2),
                             .ZERO_REG_ZERO(1'b1), .BYPASS(1'b0))
    u_dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

  typedef struct {
    int          sel;
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs(input int sel);
    case (sel)
      SEL_A_RD0:  return ifa.rdata_o[0];
      SEL_A_RD1:  return ifa.rdata_o[1];
      SEL_A_BUSY: return 64'(ifa.clear_busy_o);
      SEL_A_DONE: return 64'(ifa.clear_done_o);
      SEL_A_CONF: return 64'(ifa.wr_conflict_o);
      SEL_B_RD0:  return ifb.rdata_o[0];
      SEL_B_RD1:  return ifb.rdata_o[1];
      SEL_B_BUSY: return 64'(ifb.clear_busy_o);
      SEL_B_DONE: return 64'(ifb.clear_done_o);
      SEL_B_CONF: return 64'(ifb.wr_conflict_o);
      default:    return 64'hdead;
    endcase
  endfunction

  task automatic expect_out(input int sel, input string tag, input logic [63:0] exp);
    exp_t e;
    e.sel = sel;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ifa.we_i = '0; ifa.waddr_i = '0; ifa.wdata_i = '0; ifa.raddr_i = '0; ifa.clear_req_i = 1'b0;
    ifb.we_i = '0; ifb.waddr_i = '0; ifb.wdata_i = '0; ifb.raddr_i = '0; ifb.clear_req_i = 1'b0;
  endtask

  int done_cnt;
  int found;

  initial begin
    idle_in();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state: every address (including out-of-range ones on B) reads zero, status low.
    for (int a = 0; a < 32; a++) begin
      ifa.raddr_i[0] = 5'(a);
      ifa.raddr_i[1] = 5'(31 - a);
      ifb.raddr_i[0] = 5'(a);
      expect_out(SEL_A_RD0, "rst_rd_a0", 64'h0);
      expect_out(SEL_A_RD1, "rst_rd_a1", 64'h0);
      expect_out(SEL_B_RD0, "rst_rd_b0", 64'h0);
      drain();
      tick();
    end
    expect_out(SEL_A_BUSY, "rst_busy_a", 64'h0);
    expect_out(SEL_A_DONE, "rst_done_a", 64'h0);
    expect_out(SEL_A_CONF, "rst_conf_a", 64'h0);
    expect_out(SEL_B_BUSY, "rst_busy_b", 64'h0);
    drain();
    tick();

    // Same-cycle write/read: A forwards, B shows the old value until after the edge.
    ifa.we_i[0] = 1'b1; ifa.waddr_i[0] = 5'd5; ifa.wdata_i[0] = 64'hA5; ifa.raddr_i[0] = 5'd5;
    ifb.we_i[0] = 1'b1; ifb.waddr_i[0] = 5'd5; ifb.wdata_i[0] = 64'hA5; ifb.raddr_i[0] = 5'd5;
    expect_out(SEL_A_RD0, "byp_same_a", 64'hA5);
    expect_out(SEL_B_RD0, "nobyp_same_b", 64'h0);
    drain();
    tick();
    ifa.we_i = '0; ifb.we_i = '0;
    expect_out(SEL_A_RD0, "byp_next_a", 64'hA5);
    expect_out(SEL_B_RD0, "nobyp_next_b", 64'hA5);
    drain();
    tick();

    // Two ports on word 7: port 1 wins, conflict flagged for exactly one cycle.
    ifa.we_i = 2'b11; ifa.waddr_i[0] = 5'd7; ifa.waddr_i[1] = 5'd7;
    ifa.wdata_i[0] = 64'h11; ifa.wdata_i[1] = 64'h22; ifa.raddr_i[1] = 5'd7;
    expect_out(SEL_A_RD1, "prio_byp", 64'h22);
    expect_out(SEL_A_CONF, "conf_before", 64'h0);
    drain();
    tick();
    ifa.we_i = '0;
    expect_out(SEL_A_RD1, "prio_stored", 64'h22);
    expect_out(SEL_A_CONF, "conf_set", 64'h1);
    drain();
    tick();
    expect_out(SEL_A_CONF, "conf_clr", 64'h0);
    drain();

    // Both ports on word 0: dropped, not a conflict, never forwarded.
    ifa.we_i = 2'b11; ifa.waddr_i[0] = 5'd0; ifa.waddr_i[1] = 5'd0;
    ifa.wdata_i[0] = 64'h33; ifa.wdata_i[1] = 64'h44; ifa.raddr_i[0] = 5'd0;
    expect_out(SEL_A_RD0, "zero_byp", 64'h0);
    drain();
    tick();
    ifa.we_i = '0;
    expect_out(SEL_A_RD0, "zero_stored", 64'h0);
    expect_out(SEL_A_CONF, "zero_noconf", 64'h0);
    drain();
    tick();

    // Out-of-range on the 24-word file: write ignored, read zero, no conflict.
    ifb.we_i = 2'b11; ifb.waddr_i[0] = 5'd30; ifb.waddr_i[1] = 5'd30;
    ifb.wdata_i[0] = 64'hFF; ifb.wdata_i[1] = 64'hEE; ifb.raddr_i[0] = 5'd30;
    expect_out(SEL_B_RD0, "oor_same_b", 64'h0);
    drain();
    tick();
    ifb.we_i = '0;
    expect_out(SEL_B_RD0, "oor_next_b", 64'h0);
    expect_out(SEL_B_CONF, "oor_noconf_b", 64'h0);
    drain();

    // Fill every word with its index.
    for (int k = 1; k < 32; k++) begin
      ifa.we_i = 2'b01; ifa.waddr_i[0] = 5'(k); ifa.wdata_i[0] = 64'(k);
      ifb.we_i = (k < 24) ? 2'b01 : 2'b00; ifb.waddr_i[0] = 5'(k); ifb.wdata_i[0] = 64'(k);
      tick();
    end
    idle_in();
    ifa.raddr_i[0] = 5'd31; ifb.raddr_i[0] = 5'd23;
    expect_out(SEL_A_RD0, "fill_a31", 64'd31);
    expect_out(SEL_B_RD0, "fill_b23", 64'd23);
    drain();

    // Single-cycle clear request; write 0x55 to word 20 on the edge that clears it.
    ifa.clear_req_i = 1'b1; ifb.clear_req_i = 1'b1;
    tick();
    ifa.clear_req_i = 1'b0; ifb.clear_req_i = 1'b0;
    for (int cyc = 0; cyc < 34; cyc++) begin
      ifa.we_i = (cyc == 20) ? 2'b01 : 2'b00; ifa.waddr_i[0] = 5'd20; ifa.wdata_i[0] = 64'h55;
      ifb.we_i = (cyc == 20) ? 2'b01 : 2'b00; ifb.waddr_i[0] = 5'd20; ifb.wdata_i[0] = 64'h55;
      expect_out(SEL_A_BUSY, $sformatf("clr_busy_a_c%0d", cyc), 64'(cyc < 32));
      expect_out(SEL_A_DONE, $sformatf("clr_done_a_c%0d", cyc), 64'(cyc == 32));
      expect_out(SEL_B_BUSY, $sformatf("clr_busy_b_c%0d", cyc), 64'(cyc < 24));
      expect_out(SEL_B_DONE, $sformatf("clr_done_b_c%0d", cyc), 64'(cyc == 24));
      drain();
      tick();
    end
    idle_in();
    for (int a = 0; a < 32; a++) begin
      ifa.raddr_i[0] = 5'(a);
      ifb.raddr_i[0] = 5'(a);
      expect_out(SEL_A_RD0, $sformatf("clr_rd_a%0d", a), (a == 20) ? 64'h55 : 64'h0);
      expect_out(SEL_B_RD0, $sformatf("clr_rd_b%0d", a), (a == 20) ? 64'h55 : 64'h0);
      drain();
      tick();
    end

    // Reset during clear cycle 10: contents zeroed at once, no done pulse afterwards.
    ifa.we_i = 2'b11; ifa.waddr_i[0] = 5'd3; ifa.wdata_i[0] = 64'h33;
    ifa.waddr_i[1] = 5'd25; ifa.wdata_i[1] = 64'h77;
    tick();
    ifa.we_i = '0;
    ifa.clear_req_i = 1'b1;
    tick();
    ifa.clear_req_i = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) tick();
    ifa.raddr_i[0] = 5'd25; ifa.raddr_i[1] = 5'd3;
    expect_out(SEL_A_RD0, "midclr_w25", 64'h77);
    expect_out(SEL_A_RD1, "midclr_w3", 64'h0);
    expect_out(SEL_A_BUSY, "midclr_busy", 64'h1);
    drain();
    @(posedge clk);
    #1 rst = 1'b1;
    expect_out(SEL_A_RD0, "rstclr_w25", 64'h0);
    expect_out(SEL_A_BUSY, "rstclr_busy", 64'h0);
    expect_out(SEL_A_DONE, "rstclr_done", 64'h0);
    drain();
    tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (ifa.clear_done_o) done_cnt++;
      tick();
    end
    chk("rstclr_no_done", 64'(done_cnt), 64'h0);

    // Held request: after the done pulse one IDLE cycle, then the next clear runs.
    ifa.clear_req_i = 1'b1;
    found = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (ifa.clear_done_o) begin
        found = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("hold_done_seen", 64'(found), 64'h1);
    if (found == 1) begin
      tick();
      expect_out(SEL_A_BUSY, "hold_idle_busy", 64'h0);
      expect_out(SEL_A_DONE, "hold_idle_done", 64'h0);
      drain();
      tick();
      expect_out(SEL_A_BUSY, "hold_restart_busy", 64'h1);
      drain();
    end
    ifa.clear_req_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
